// File: rtl/global_mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CORES core global-memory ports onto one memory port.
// One transaction in flight at a time: grant in IDLE, hold the request in ISSUE, report in RESPOND.
module global_mem_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUM_CORES-1:0]      coreReadReq,
    input  logic [NUM_CORES-1:0]      coreWriteReq,
    input  logic [32*NUM_CORES-1:0]   coreMar,
    input  logic [32*NUM_CORES-1:0]   coreMdr,
    output logic [NUM_CORES-1:0]      coreFinishedRead,
    output logic [NUM_CORES-1:0]      coreFinishedWrite,
    output logic [31:0]               coreReadData,
    output logic                      memReq,
    output logic                      memWe,
    output logic [31:0]               memAddr,
    output logic [31:0]               memWData,
    input  logic                      memAck,
    input  logic [31:0]               memRData,
    output logic                      errTimeout
);

    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StRespond} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [NUM_CORES-1:0] req;
    logic [IdxW-1:0]      pick;
    logic                 found;
    int unsigned          idx;

    assign req = coreReadReq | coreWriteReq;

    // First requester at or above rr_ptr_q, wrapping around the core count.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_CORES;
            if (!found && req[idx[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        tmo_cnt_d = tmo_cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    // Read wins when a core raises both request lines.
                    we_d    = ~coreReadReq[pick];
                    addr_d  = coreMar[{pick, 5'b00000} +: 32];
                    wdata_d = coreMdr[{pick, 5'b00000} +: 32];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (memAck) begin
                    rdata_d = memRData;
                    state_d = StRespond;
                end else if (tmo_cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = 32'hDEADBEEF;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                rr_ptr_d  = (grant_q == IdxW'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
                tmo_cnt_d = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tmo_cnt_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tmo_cnt_q <= tmo_cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign memReq       = (state_q == StIssue);
    assign memWe        = we_q;
    assign memAddr      = addr_q;
    assign memWData     = wdata_q;
    assign coreReadData = rdata_q;
    assign errTimeout   = err_q;

    always_comb begin
        coreFinishedRead  = '0;
        coreFinishedWrite = '0;
        if (state_q == StRespond) begin
            if (we_q) begin
                coreFinishedWrite[grant_q] = 1'b1;
            end else begin
                coreFinishedRead[grant_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Bench for global_mem_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_global_mem_arbiter;

    localparam int NC  = 4;
    localparam int TMO = 255;

    logic              clk = 1'b0;
    logic              resetN;
    logic [NC-1:0]     coreReadReq, coreWriteReq;
    logic [32*NC-1:0]  coreMar, coreMdr;
    logic [NC-1:0]     coreFinishedRead, coreFinishedWrite;
    logic [31:0]       coreReadData;
    logic              memReq, memWe, memAck, errTimeout;
    logic [31:0]       memAddr, memWData, memRData;

    always #5 clk = ~clk;

    global_mem_arbiter #(.NUM_CORES(NC), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .resetN            (resetN),
        .coreReadReq       (coreReadReq),
        .coreWriteReq      (coreWriteReq),
        .coreMar           (coreMar),
        .coreMdr           (coreMdr),
        .coreFinishedRead  (coreFinishedRead),
        .coreFinishedWrite (coreFinishedWrite),
        .coreReadData      (coreReadData),
        .memReq            (memReq),
        .memWe             (memWe),
        .memAddr           (memAddr),
        .memWData          (memWData),
        .memAck            (memAck),
        .memRData          (memRData),
        .errTimeout        (errTimeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder controls
    int          icnt = 0;
    int          ack_lat = 0;
    bit          ack_never = 0, junk_en = 0, rand_lat = 0, fixed_en = 0, late_ack = 0;
    logic [31:0] fixed_data = '0;

    // Transaction-level model: which core is being served, where its transaction stands.
    // m_phase: 0 waiting for requests, 1 memory busy, 2 reporting completion.
    bit          m_valid = 0;
    int          m_phase, m_core, m_rr, m_wait;
    bit          m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic int rr_pick(input logic [NC-1:0] r, input int ptr);
        for (int d = 0; d < NC; d++) begin
            if (r[(ptr + d) % NC]) return (ptr + d) % NC;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!resetN) begin
                m_phase = 0; m_core = 0; m_rr = 0; m_wait = 0;
                m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
                m_valid = 1;
            end else if (m_valid) begin
                if (m_phase == 0) begin
                    if ((coreReadReq | coreWriteReq) != '0) begin
                        m_core  = rr_pick(coreReadReq | coreWriteReq, m_rr);
                        m_we    = !coreReadReq[m_core];
                        m_addr  = coreMar[32*m_core +: 32];
                        m_wdata = coreMdr[32*m_core +: 32];
                        m_wait  = 0;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (memAck) begin
                        m_rdata = memRData;
                        m_phase = 2;
                    end else if (m_wait == TMO - 1) begin
                        m_err   = 1;
                        m_rdata = 32'hDEADBEEF;
                        m_phase = 2;
                    end else begin
                        m_wait++;
                    end
                end else begin
                    m_rr    = (m_core + 1) % NC;
                    m_phase = 0;
                end
            end
        end
    end

    initial begin
        logic [NC-1:0] e_fr, e_fw;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_fr = '0;
                e_fw = '0;
                if (m_phase == 2) begin
                    if (m_we) e_fw[m_core] = 1'b1;
                    else      e_fr[m_core] = 1'b1;
                end
                chk("memReq", 32'(memReq), 32'(m_phase == 1));
                chk("finRead", 32'(coreFinishedRead), 32'(e_fr));
                chk("finWrite", 32'(coreFinishedWrite), 32'(e_fw));
                chk("readData", coreReadData, m_rdata);
                chk("errTimeout", 32'(errTimeout), 32'(m_err));
                if (m_phase == 1) begin
                    chk("memWe", 32'(memWe), 32'(m_we));
                    chk("memAddr", memAddr, m_addr);
                    chk("memWData", memWData, m_wdata);
                end
            end
        end
    end

    // Advance one cycle; cores drop requests after their finished pulse; memory responds.
    task automatic step();
        logic [NC-1:0] fin;
        fin = coreFinishedRead | coreFinishedWrite;
        @(posedge clk);
        #2;
        coreReadReq  &= ~fin;
        coreWriteReq &= ~fin;
        if (memReq) begin
            memAck = !ack_never && (icnt == ack_lat);
            icnt++;
        end else begin
            icnt   = 0;
            memAck = junk_en ? 1'($urandom_range(0, 1)) : late_ack;
            if (rand_lat) begin
                ack_lat   = $urandom_range(0, 5);
                ack_never = ($urandom_range(0, 149) == 0);
            end
        end
        memRData = fixed_en ? fixed_data : $urandom;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (!memReq && n < budget) begin
            step();
            n++;
        end
        chk("wait_memReq", 32'(memReq), 32'd1);
    endtask

    task automatic wait_fin(input int budget, output int n);
        n = 0;
        while ((coreFinishedRead | coreFinishedWrite) == '0 && n < budget) begin
            step();
            n++;
        end
        chk("wait_finished", 32'(|(coreFinishedRead | coreFinishedWrite)), 32'd1);
    endtask

    initial begin
        int n;
        int order[3];
        order = '{0, 1, 3};
        resetN = 1'b0;
        coreReadReq = '0; coreWriteReq = '0; coreMar = '0; coreMdr = '0;
        memAck = 1'b0; memRData = '0;
        step();
        step();
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memWe", 32'(memWe), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memWData", memWData, 32'd0);
        chk("rst_fin", 32'({coreFinishedRead, coreFinishedWrite}), 32'd0);
        chk("rst_readData", coreReadData, 32'd0);
        chk("rst_err", 32'(errTimeout), 32'd0);
        resetN = 1'b1;
        step();

        // Single read from core 2, ack three cycles into the request
        fixed_en = 1; fixed_data = 32'h12345678; ack_lat = 3;
        coreMar[64 +: 32] = 32'h100;
        coreReadReq[2] = 1'b1;
        step();
        wait_req(4, n);
        chk("rd_grant_latency", n, 0);
        chk("rd_memWe", 32'(memWe), 32'd0);
        chk("rd_memAddr", memAddr, 32'h100);
        wait_fin(10, n);
        chk("rd_ack_latency", n, 4);
        chk("rd_finRead", 32'(coreFinishedRead), 32'b0100);
        chk("rd_finWrite", 32'(coreFinishedWrite), 32'd0);
        chk("rd_data", coreReadData, 32'h12345678);
        step();
        chk("rd_pulse_once", 32'(coreFinishedRead), 32'd0);

        // Round-robin wrap: pointer sits at 3, cores 0 and 3 write
        ack_lat = 0;
        coreMar[0 +: 32] = 32'hA0; coreMdr[0 +: 32] = 32'h11;
        coreMar[96 +: 32] = 32'hA3; coreMdr[96 +: 32] = 32'h33;
        coreWriteReq = 4'b1001;
        step();
        wait_req(4, n);
        chk("wrap_first_addr", memAddr, 32'hA3);
        chk("wrap_first_wdata", memWData, 32'h33);
        chk("wrap_first_we", 32'(memWe), 32'd1);
        wait_fin(4, n);
        chk("min_latency", n, 1);
        chk("wrap_first_fin", 32'(coreFinishedWrite), 32'b1000);
        wait_req(4, n);
        chk("wrap_second_addr", memAddr, 32'hA0);
        wait_fin(4, n);
        chk("wrap_second_fin", 32'(coreFinishedWrite), 32'b0001);

        // Contention from reset: cores 0, 1, 3 write together
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        for (int k = 0; k < NC; k++) begin
            coreMar[32*k +: 32] = 32'h1000 + k;
            coreMdr[32*k +: 32] = 32'hC0DE0000 + k;
        end
        coreWriteReq = 4'b1011;
        for (int j = 0; j < 3; j++) begin
            wait_req(6, n);
            chk("cont_addr", memAddr, 32'h1000 + order[j]);
            chk("cont_wdata", memWData, 32'hC0DE0000 + order[j]);
            wait_fin(4, n);
            chk("cont_fin", 32'(coreFinishedWrite), 32'(1) << order[j]);
        end

        // Back-to-back read then write from core 1
        step();
        ack_lat = 1; fixed_data = 32'hCAFE0001;
        coreMar[32 +: 32] = 32'h200;
        coreReadReq[1] = 1'b1;
        wait_req(6, n);
        chk("b2b_rd_we", 32'(memWe), 32'd0);
        chk("b2b_rd_addr", memAddr, 32'h200);
        wait_fin(6, n);
        chk("b2b_rd_fin", 32'(coreFinishedRead), 32'b0010);
        chk("b2b_rd_data", coreReadData, 32'hCAFE0001);
        step();
        chk("b2b_gap1", 32'({coreFinishedRead, coreFinishedWrite}), 32'd0);
        step();
        chk("b2b_gap2", 32'({coreFinishedRead, coreFinishedWrite}), 32'd0);
        coreMar[32 +: 32] = 32'h204; coreMdr[32 +: 32] = 32'h55AA;
        coreWriteReq[1] = 1'b1;
        wait_req(6, n);
        chk("b2b_wr_we", 32'(memWe), 32'd1);
        chk("b2b_wr_addr", memAddr, 32'h204);
        chk("b2b_wr_wdata", memWData, 32'h55AA);
        wait_fin(6, n);
        chk("b2b_wr_fin", 32'(coreFinishedWrite), 32'b0010);
        chk("b2b_wr_nord", 32'(coreFinishedRead), 32'd0);

        // Timeout: read that memory never acknowledges
        step();
        ack_never = 1;
        coreMar[0 +: 32] = 32'h300;
        coreReadReq[0] = 1'b1;
        wait_req(6, n);
        n = 1;
        while (n < 400) begin
            step();
            if (!memReq) break;
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_err", 32'(errTimeout), 32'd1);
        chk("tmo_fin", 32'(coreFinishedRead), 32'b0001);
        chk("tmo_data", coreReadData, 32'hDEADBEEF);
        ack_never = 0; late_ack = 1;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("late_ack_req", 32'(memReq), 32'd0);
            chk("late_ack_fin", 32'({coreFinishedRead, coreFinishedWrite}), 32'd0);
            chk("late_ack_data", coreReadData, 32'hDEADBEEF);
            chk("late_ack_err", 32'(errTimeout), 32'd1);
        end
        late_ack = 0;

        // Reset in the middle of an outstanding request
        ack_never = 1;
        coreReadReq[2] = 1'b1;
        wait_req(6, n);
        step();
        step();
        resetN = 1'b0;
        step();
        chk("midrst_memReq", 32'(memReq), 32'd0);
        chk("midrst_err", 32'(errTimeout), 32'd0);
        chk("midrst_fin", 32'({coreFinishedRead, coreFinishedWrite}), 32'd0);
        resetN = 1'b1;
        ack_never = 0; ack_lat = 0;
        coreMar[0 +: 32] = 32'h400; coreMar[96 +: 32] = 32'h403;
        coreReadReq = 4'b1001;
        step();
        wait_req(4, n);
        chk("midrst_next_addr", memAddr, 32'h400);
        wait_fin(4, n);
        chk("midrst_next_fin", 32'(coreFinishedRead), 32'b0001);
        wait_req(6, n);
        chk("midrst_then_addr", memAddr, 32'h403);
        wait_fin(4, n);

        // Randomized traffic against the model
        junk_en = 1; rand_lat = 1; fixed_en = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NC; k++) begin
                if (!coreReadReq[k] && !coreWriteReq[k] && $urandom_range(0, 7) == 0) begin
                    int r;
                    r = $urandom_range(0, 2);
                    coreReadReq[k]  = (r != 1);
                    coreWriteReq[k] = (r != 0);
                    coreMar[32*k +: 32] = $urandom;
                    coreMdr[32*k +: 32] = $urandom;
                end
            end
            resetN = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/global_mem_arbiter.md
GLOBAL_MEM_ARBITER -- requirements
Module: global_mem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CORES, 4, number of attached gpuCore global-memory ports; TIMEOUT, 255, max ISSUE cycles before abort.
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 resetN  in  1  synchronous active-low reset.
REQ-005 coreReadReq  in  NUM_CORES  per-core readingMemoryDataGlobal, level-held until finished.
REQ-006 coreWriteReq  in  NUM_CORES  per-core writingMemoryDataGlobal, level-held until finished.
REQ-007 coreMar  in  32*NUM_CORES  per-core marOut, core i at bits [32i+31:32i].
REQ-008 coreMdr  in  32*NUM_CORES  per-core mdrOut, same packing.
REQ-009 coreFinishedRead  out  NUM_CORES  one-hot finishedReadMemoryDataGlobal pulse.
REQ-010 coreFinishedWrite  out  NUM_CORES  one-hot finishedWriteMemoryDataGlobal pulse.
REQ-011 coreReadData  out  32  broadcast MDRIn, valid while any coreFinishedRead bit is high.
REQ-012 memReq  out  1  memory request, held until memAck or timeout.
REQ-013 memWe  out  1  1 = write, 0 = read; valid with memReq.
REQ-014 memAddr  out  32  word address; valid with memReq.
REQ-015 memWData  out  32  write data; valid with memReq.
REQ-016 memAck  in  1  memory done; memRData valid in the same cycle.
REQ-017 memRData  in  32  read data.
REQ-018 errTimeout  out  1  sticky timeout flag.

Function
REQ-019 FSM SHALL have states IDLE, ISSUE, RESPOND; all outputs SHALL be registered or decoded from state and latched registers only.
REQ-020 IDLE: at an edge where req = coreReadReq|coreWriteReq is nonzero, grant the first set bit at or above rrPtr (modulo NUM_CORES, wrapping); latch grant index, coreMar, coreMdr, and we = ~coreReadReq[g]; go ISSUE.
REQ-021 A core asserting both read and write SHALL be served as a read.
REQ-022 ISSUE: memReq=1 with latched we/addr/wdata, held stable; tmoCnt increments each cycle.
REQ-023 ISSUE with memAck=1: latch memRData into rdata; go RESPOND; memReq low from the next cycle.
REQ-024 ISSUE with tmoCnt==TIMEOUT-1 and memAck=0: set errTimeout, rdata=32'hDEADBEEF, go RESPOND.
REQ-025 RESPOND (exactly 1 cycle): coreFinishedRead[g]=~we or coreFinishedWrite[g]=we, coreReadData=rdata; rrPtr <= (g+1) mod NUM_CORES; tmoCnt <= 0; go IDLE.
REQ-026 Requests SHALL be ignored in ISSUE and RESPOND; the granted core's still-high request in RESPOND SHALL NOT cause a re-grant.
REQ-027 memAck outside ISSUE SHALL be ignored.
REQ-028 Minimum latency: request seen at edge T; memReq high in cycle T+1; ack in T+1 gives the finished pulse in T+2.
REQ-029 coreReadData SHALL hold its last value outside RESPOND; finished bits SHALL be zero outside RESPOND.
REQ-030 errTimeout SHALL clear only on reset.

Reset
REQ-031 resetN=0 at an edge SHALL force IDLE, rrPtr=0, tmoCnt=0, grant=0, rdata=0, errTimeout=0; memReq, memWe, memAddr, memWData, coreFinished*, and coreReadData all become 0 from the next cycle, including mid-ISSUE.
REQ-032 The first request after reset SHALL be evaluated from rrPtr=0.

Verification
REQ-033 Single read: core2 reads with coreMar=0x100; memAck 3 cycles after memReq with memRData=0x12345678 -> memWe=0, memAddr=0x100; coreFinishedRead=4'b0100 for 1 cycle with coreReadData=0x12345678.
REQ-034 Contention: cores 0, 1, and 3 write simultaneously from reset; memAck immediate -> served in order 0, 1, 3, each with one coreFinishedWrite pulse; memAddr/memWData match each core's MAR/MDR.
REQ-035 Round-robin wrap: rrPtr=3 after serving core2; cores 0 and 3 request -> core3 served first, then core0.
REQ-036 Timeout: read with memAck never asserted -> memReq drops after 255 cycles; errTimeout=1; coreReadData=0xDEADBEEF with the finished pulse; a late memAck has no effect.
REQ-037 Reset mid-ISSUE: resetN=0 while memReq=1 -> memReq=0 and errTimeout=0 the next cycle; no finished pulse; the next request is granted from core0.
REQ-038 Back-to-back: one core issues a read, then a write 2 cycles after its finished pulse -> second grant is that core; no duplicate pulse for the first request.
